// File: rtl/shift_issue_arbiter.sv
// Two-requester round-robin front end for a shared halfword/word shift-rotate
// unit, with a LATENCY-deep result pipeline that feeds the register-file write port.
module shift_issue_arbiter #(
    parameter int LATENCY = 2,
    parameter int RT_W    = 7
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [1:0]      req0_op,
    input  logic [127:0]    req0_ra,
    input  logic [127:0]    req0_rb,
    input  logic [RT_W-1:0] req0_rt,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [1:0]      req1_op,
    input  logic [127:0]    req1_ra,
    input  logic [127:0]    req1_rb,
    input  logic [RT_W-1:0] req1_rt,
    input  logic            flush,
    output logic            wb_valid,
    output logic            wb_id,
    output logic [RT_W-1:0] wb_rt,
    output logic [127:0]    wb_data,
    output logic            busy
);

    typedef enum logic [1:0] {
        OP_SHLH = 2'b00,
        OP_SHL  = 2'b01,
        OP_ROTH = 2'b10,
        OP_ROT  = 2'b11
    } op_e;

    typedef struct packed {
        logic            valid;
        logic            id;
        logic [RT_W-1:0] rt;
        logic [127:0]    data;
    } stage_t;

    logic            last_q, last_d;
    logic            grant0, grant1;
    logic            xfer0, xfer1;
    op_e             acc_op;
    logic [127:0]    acc_ra, acc_rb, acc_res;
    logic [RT_W-1:0] acc_rt;
    logic [31:0]     hw_dbl;
    logic [63:0]     w_dbl;
    logic            unused_rb;
    stage_t          st_q [LATENCY];
    stage_t          st_d [LATENCY];

    // last_q == 1 means requester 1 won the most recent transfer, so requester 0 wins a tie.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant0     = req0_valid & (~req1_valid | last_q);
        grant1     = req1_valid & (~req0_valid | ~last_q);
        req0_ready = grant0 & ~flush;
        req1_ready = grant1 & ~flush;
        xfer0      = req0_valid & req0_ready;
        xfer1      = req1_valid & req1_ready;
        last_d     = last_q;
        if (xfer1) begin
            last_d = 1'b1;
        end else if (xfer0) begin
            last_d = 1'b0;
        end
    end

    always_comb begin
        acc_op = op_e'(req0_op);
        acc_ra = req0_ra;
        acc_rb = req0_rb;
        acc_rt = req0_rt;
        if (grant1) begin
            acc_op = op_e'(req1_op);
            acc_ra = req1_ra;
            acc_rb = req1_rb;
            acc_rt = req1_rt;
        end
    end

    // Only the low count bits of each element matter; the rest of RB is don't-care.
    assign unused_rb = ^acc_rb;

    // Shift counts at or beyond the element width flush the element to zero;
    // rotates duplicate the element and keep the upper half of the shifted pair.
    always_comb begin
        acc_res = '0;
        hw_dbl  = '0;
        w_dbl   = '0;
        case (acc_op)
            OP_SHLH: begin
                for (int i = 0; i < 8; i++) begin
                    acc_res[16*i +: 16] = acc_rb[16*i + 4] ? 16'h0000
                                        : acc_ra[16*i +: 16] << acc_rb[16*i +: 4];
                end
            end
            OP_SHL: begin
                for (int i = 0; i < 4; i++) begin
                    acc_res[32*i +: 32] = acc_rb[32*i + 5] ? 32'h0000_0000
                                        : acc_ra[32*i +: 32] << acc_rb[32*i +: 5];
                end
            end
            OP_ROTH: begin
                for (int i = 0; i < 8; i++) begin
                    hw_dbl              = {acc_ra[16*i +: 16], acc_ra[16*i +: 16]} << acc_rb[16*i +: 4];
                    acc_res[16*i +: 16] = hw_dbl[31:16];
                end
            end
            OP_ROT: begin
                for (int i = 0; i < 4; i++) begin
                    w_dbl               = {acc_ra[32*i +: 32], acc_ra[32*i +: 32]} << acc_rb[32*i +: 5];
                    acc_res[32*i +: 32] = w_dbl[63:32];
                end
            end
        endcase
    end

    // Stage 0 captures the accepted op; the last stage is the writeback register.
    // Invalid stages carry all-zero payload so wb_* reads as 0 whenever wb_valid is low.
    always_comb begin
        st_d[0] = '0;
        if (xfer0 | xfer1) begin
            st_d[0].valid = 1'b1;
            st_d[0].id    = xfer1;
            st_d[0].rt    = acc_rt;
            st_d[0].data  = acc_res;
        end
        for (int k = 1; k < LATENCY; k++) begin
            st_d[k] = st_q[k-1];
        end
        if (flush) begin
            for (int k = 0; k < LATENCY; k++) begin
                st_d[k] = '0;
            end
        end
    end

    // busy covers the stages still in flight, not the writeback register itself.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < LATENCY - 1; k++) begin
            busy = busy | st_q[k].valid;
        end
    end

    assign wb_valid = st_q[LATENCY-1].valid;
    assign wb_id    = st_q[LATENCY-1].id;
    assign wb_rt    = st_q[LATENCY-1].rt;
    assign wb_data  = st_q[LATENCY-1].data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
            // NOTE: payload registers are reset too, because the writeback outputs come straight from them.
            for (int k = 0; k < LATENCY; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
            last_q <= last_d;
            for (int k = 0; k < LATENCY; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

endmodule

// File: tb/tb_shift_issue_arbiter.sv
// Directed bench: LATENCY=2 and LATENCY=3 instances share stimulus; expected
// results are hand-computed constants carried through a per-latency delay line.
module tb_shift_issue_arbiter;

    logic         clk;
    logic         reset_n;
    logic         req0_valid, req1_valid, flush;
    logic [1:0]   req0_op, req1_op;
    logic [127:0] req0_ra, req0_rb, req1_ra, req1_rb;
    logic [6:0]   req0_rt, req1_rt;

    logic         l2_r0, l2_r1, l2_wb_valid, l2_wb_id, l2_busy;
    logic [6:0]   l2_wb_rt;
    logic [127:0] l2_wb_data;
    logic         l3_r0, l3_r1, l3_wb_valid, l3_wb_id, l3_busy;
    logic [6:0]   l3_wb_rt;
    logic [127:0] l3_wb_data;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic         valid;
        logic [1:0]   op;
        logic [6:0]   rt;
        logic [127:0] ra;
        logic [127:0] rb;
        logic [127:0] res;
    } req_t;

    typedef struct packed {
        logic         v;
        logic         id;
        logic [6:0]   rt;
        logic [127:0] d;
    } exp_t;

    exp_t exp2 [2];
    exp_t exp3 [3];

    localparam req_t IDLE = '0;

    shift_issue_arbiter #(.LATENCY(2), .RT_W(7)) u_l2 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(l2_r0), .req0_op(req0_op),
        .req0_ra(req0_ra), .req0_rb(req0_rb), .req0_rt(req0_rt),
        .req1_valid(req1_valid), .req1_ready(l2_r1), .req1_op(req1_op),
        .req1_ra(req1_ra), .req1_rb(req1_rb), .req1_rt(req1_rt),
        .flush(flush), .wb_valid(l2_wb_valid), .wb_id(l2_wb_id),
        .wb_rt(l2_wb_rt), .wb_data(l2_wb_data), .busy(l2_busy)
    );

    shift_issue_arbiter #(.LATENCY(3), .RT_W(7)) u_l3 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(l3_r0), .req0_op(req0_op),
        .req0_ra(req0_ra), .req0_rb(req0_rb), .req0_rt(req0_rt),
        .req1_valid(req1_valid), .req1_ready(l3_r1), .req1_op(req1_op),
        .req1_ra(req1_ra), .req1_rb(req1_rb), .req1_rt(req1_rt),
        .flush(flush), .wb_valid(l3_wb_valid), .wb_id(l3_wb_id),
        .wb_rt(l3_wb_rt), .wb_data(l3_wb_data), .busy(l3_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic req_t mk(input logic [1:0] op, input logic [127:0] ra,
                                input logic [127:0] rb, input logic [127:0] res,
                                input logic [6:0] rt);
        req_t r;
        r.valid = 1'b1;
        r.op    = op;
        r.rt    = rt;
        r.ra    = ra;
        r.rb    = rb;
        r.res   = res;
        return r;
    endfunction

    // Rotate by zero: result equals RA, which carries the rt number for easy tracing.
    function automatic req_t ident(input logic [6:0] rt);
        return mk(2'b11, {16{1'b0, rt}}, 128'h0, {16{1'b0, rt}}, rt);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++) exp2[k] = '0;
        for (int k = 0; k < 3; k++) exp3[k] = '0;
    endtask

    // Entered at a falling edge: checks outputs, drives one cycle of stimulus,
    // checks the readys, then advances the expected pipeline across the rising edge.
    task automatic cycle(input string nm, input req_t r0, input req_t r1,
                         input logic fl, input logic g0, input logic g1);
        exp_t nxt;
        check($sformatf("%s l2_wb_valid", nm), 128'(l2_wb_valid), 128'(exp2[1].v));
        check($sformatf("%s l2_wb_id", nm),    128'(l2_wb_id),    128'(exp2[1].id));
        check($sformatf("%s l2_wb_rt", nm),    128'(l2_wb_rt),    128'(exp2[1].rt));
        check($sformatf("%s l2_wb_data", nm),  l2_wb_data,        exp2[1].d);
        check($sformatf("%s l2_busy", nm),     128'(l2_busy),     128'(exp2[0].v));
        check($sformatf("%s l3_wb_valid", nm), 128'(l3_wb_valid), 128'(exp3[2].v));
        check($sformatf("%s l3_wb_id", nm),    128'(l3_wb_id),    128'(exp3[2].id));
        check($sformatf("%s l3_wb_rt", nm),    128'(l3_wb_rt),    128'(exp3[2].rt));
        check($sformatf("%s l3_wb_data", nm),  l3_wb_data,        exp3[2].d);
        check($sformatf("%s l3_busy", nm),     128'(l3_busy),     128'(exp3[0].v | exp3[1].v));

        req0_valid = r0.valid; req0_op = r0.op; req0_ra = r0.ra; req0_rb = r0.rb; req0_rt = r0.rt;
        req1_valid = r1.valid; req1_op = r1.op; req1_ra = r1.ra; req1_rb = r1.rb; req1_rt = r1.rt;
        flush      = fl;
        #1;
        check($sformatf("%s l2_req0_ready", nm), 128'(l2_r0), 128'(g0 & ~fl));
        check($sformatf("%s l2_req1_ready", nm), 128'(l2_r1), 128'(g1 & ~fl));
        check($sformatf("%s l3_req0_ready", nm), 128'(l3_r0), 128'(g0 & ~fl));
        check($sformatf("%s l3_req1_ready", nm), 128'(l3_r1), 128'(g1 & ~fl));

        @(posedge clk);
        nxt = '0;
        if (!fl && g0) begin
            nxt = {1'b1, 1'b0, r0.rt, r0.res};
        end else if (!fl && g1) begin
            nxt = {1'b1, 1'b1, r1.rt, r1.res};
        end
        if (fl) begin
            clear_model();
        end else begin
            exp2[1] = exp2[0]; exp2[0] = nxt;
            exp3[2] = exp3[1]; exp3[1] = exp3[0]; exp3[0] = nxt;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string nm);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush      = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check($sformatf("%s l2_wb_valid", nm), 128'(l2_wb_valid), 128'(0));
        check($sformatf("%s l2_wb_id", nm),    128'(l2_wb_id),    128'(0));
        check($sformatf("%s l2_wb_rt", nm),    128'(l2_wb_rt),    128'(0));
        check($sformatf("%s l2_wb_data", nm),  l2_wb_data,        128'(0));
        check($sformatf("%s l2_busy", nm),     128'(l2_busy),     128'(0));
        check($sformatf("%s l3_wb_valid", nm), 128'(l3_wb_valid), 128'(0));
        check($sformatf("%s l3_busy", nm),     128'(l3_busy),     128'(0));
        clear_model();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        req0_valid = 1'b0; req0_op = 2'b00; req0_ra = '0; req0_rb = '0; req0_rt = '0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_ra = '0; req1_rb = '0; req1_rt = '0;
        flush      = 1'b0;
        clear_model();
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state, then contention: grants alternate starting with req0.
        cycle("idle",  IDLE, IDLE, 1'b0, 1'b0, 1'b0);
        cycle("cont0", ident(7'd1), ident(7'd9),  1'b0, 1'b1, 1'b0);
        cycle("cont1", ident(7'd2), ident(7'd9),  1'b0, 1'b0, 1'b1);
        cycle("cont2", ident(7'd2), ident(7'd10), 1'b0, 1'b1, 1'b0);
        cycle("cont3", ident(7'd3), ident(7'd10), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle($sformatf("drain_c%0d", i), IDLE, IDLE, 1'b0, 1'b0, 1'b0);

        // Single shlh op from req0.
        cycle("single", mk(2'b00, {8{16'h8001}}, {8{16'h0001}}, {8{16'h0002}}, 7'd5),
              IDLE, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle($sformatf("drain_s%0d", i), IDLE, IDLE, 1'b0, 1'b0, 1'b0);

        // Boundary counts from req1, back to back.
        cycle("b_shlh", IDLE,
              mk(2'b00, {8{16'hFFFF}},
                 {{5{16'h0010}}, 16'h000F, 16'h0020, 16'h0010},
                 {{5{16'h0000}}, 16'h8000, 16'hFFFF, 16'h0000}, 7'd20),
              1'b0, 1'b0, 1'b1);
        cycle("b_shl", IDLE,
              mk(2'b01, {4{32'h0000_0001}},
                 {32'h0000_003F, 32'h0000_0040, 32'd32, 32'd31},
                 {32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000}, 7'd21),
              1'b0, 1'b0, 1'b1);
        cycle("b_roth", IDLE,
              mk(2'b10, {8{16'h8001}},
                 {{6{16'h0011}}, 16'h0004, 16'h0011},
                 {{6{16'h0003}}, 16'h0018, 16'h0003}, 7'd22),
              1'b0, 1'b0, 1'b1);
        cycle("b_rot", IDLE,
              mk(2'b11, {4{32'h1234_5678}},
                 {32'h0000_0108, 32'h0000_0000, 32'h0000_0004, 32'd32},
                 {32'h3456_7812, 32'h1234_5678, 32'h2345_6781, 32'h1234_5678}, 7'd23),
              1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle($sformatf("drain_b%0d", i), IDLE, IDLE, 1'b0, 1'b0, 1'b0);

        // Flush one cycle after the second accept; both requesters valid but blocked.
        cycle("f_op0", mk(2'b01, {4{32'h0000_0001}}, {4{32'd4}}, {4{32'h0000_0010}}, 7'd30),
              IDLE, 1'b0, 1'b1, 1'b0);
        cycle("f_op1", IDLE,
              mk(2'b10, {8{16'h1234}}, {8{16'h0004}}, {8{16'h2341}}, 7'd31),
              1'b0, 1'b0, 1'b1);
        cycle("flush", ident(7'd32), ident(7'd33), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle($sformatf("post_flush%0d", i), IDLE, IDLE, 1'b0, 1'b0, 1'b0);
        cycle("flush_idle", IDLE, IDLE, 1'b1, 1'b0, 1'b0);
        cycle("after_flush", ident(7'd5), ident(7'd13), 1'b0, 1'b1, 1'b0);

        // Reset with ops in flight; RR must restart at req0.
        cycle("r_op0", mk(2'b00, {8{16'h00FF}}, {8{16'h0008}}, {8{16'hFF00}}, 7'd40),
              IDLE, 1'b0, 1'b1, 1'b0);
        cycle("r_op1", mk(2'b11, {4{32'hF000_0000}}, {4{32'd4}}, {4{32'h0000_000F}}, 7'd41),
              IDLE, 1'b0, 1'b1, 1'b0);
        do_reset("mid_reset");
        cycle("post_rst", ident(7'd6), ident(7'd14), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle($sformatf("drain_r%0d", i), IDLE, IDLE, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/shift_issue_arbiter.md
Name: shift_issue_arbiter

Overview:
- Shares one halfword/word shift-rotate datapath between two issue requesters.
- Performs round-robin arbitration, valid/ready acceptance and LATENCY-stage result pipelining, with register-file writeback tagging.
- Sits between the issue slots and the register-file write port.
- Supports flush of in-flight operations.

Parameters:
LATENCY, 2, pipeline depth from accept to writeback; legal 1..8
RT_W, 7, register-file target address width

Ports:
clk  input  1  clock, rising-edge
reset_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an op
req0_ready  output  1  requester 0 op accepted this cycle when high with valid
req0_op  input  2  00 shlh, 01 shl, 10 roth, 11 rot
req0_ra  input  128  source operand
req0_rb  input  128  shift-count operand
req0_rt  input  RT_W  destination register
req1_valid, req1_ready, req1_op, req1_ra, req1_rb, req1_rt  same as requester 0
flush  input  1  kill all in-flight ops, block acceptance this cycle
wb_valid  output  1  writeback result valid
wb_id  output  1  requester that issued the result
wb_rt  output  RT_W  destination register
wb_data  output  128  result
busy  output  1  any pipeline stage valid

Behaviour:
- Reset (async, reset_n=0): all pipeline stage valids 0; wb_valid, wb_id, wb_rt, wb_data, busy = 0; RR pointer = "last granted 1", so req0 wins the first tie. In-flight ops are lost.
- Arbitration is combinational:
  - Only one requester valid: it is granted.
  - Both valid: grant the requester not last granted.
  - reqN_ready = grantN & !flush. The non-granted ready is 0.
  - A transfer occurs when reqN_valid & reqN_ready.
  - RR pointer updates only on a transfer.
  - No starvation: with both valid continuously, grants alternate 0,1,0,1.
- Full throughput: one accept per cycle, no bubbles. Writeback has no backpressure.
- Datapath (element i of halfword = bits [16i+15:16i], word = bits [32i+31:32i]; "left" = toward MSB, same as <<):
  - shlh: per halfword, count = RB halfword[4:0]. count >= 16 gives 0; otherwise RA_h << count, zero fill.
  - shl: per word, count = RB word[5:0]. count >= 32 gives 0; otherwise RA_w << count.
  - roth: per halfword, rotate left by RB halfword[3:0].
  - rot: per word, rotate left by RB word[4:0].
  - Ignored count bits have no effect.
- Latency: op accepted at rising edge t appears with wb_valid=1 in the cycle after edge t+LATENCY-1. LATENCY=1 means wb_valid is high the cycle immediately after the accept edge.
- Order: results leave in acceptance order with matching wb_id/wb_rt.
- When wb_valid=0, wb_id, wb_rt and wb_data are 0.
- Flush (synchronous):
  - In the flush cycle, both readys are 0 and nothing is accepted.
  - At the next edge, all stage valids clear; ops that would have written back at or after that edge never appear.
  - wb_valid is still 1 for a result presented in the flush cycle itself, which completes.
- flush with both requesters idle: no effect besides a 0 ready.
- busy = OR of stage valids; it excludes wb_valid from the cycle after the final stage.
- Inputs are sampled only on transfer; RA/RB may change freely otherwise.

Test Plan:
- Reset then idle: reset_n pulsed low mid-cycle → all outputs 0 immediately; busy=0; first contended grant goes to req0.
- Single op, LATENCY=2: req0 shlh, RA halfwords all 16'h8001, RB halfwords 1, rt=5 → accepted in the same cycle; wb_valid two cycles later; wb_data halfwords 16'h0002, wb_rt=5, wb_id=0.
- Boundary counts: shlh count 16 → 0; shl count 31 on 32'h00000001 → 32'h80000000; roth count 17 (uses [3:0]=1) on 16'h8001 → 16'h0003; rot count 32 on 32'h12345678 → unchanged.
- Contention: both valid for 4 cycles with distinct rt 1..4 and 9..12 → grants 0,1,0,1; writeback order rt 1,9,2,10 with matching wb_id; no bubbles.
- Flush: accept 2 ops on consecutive cycles, assert flush the cycle after the second accept (LATENCY=3) → readys 0 that cycle; neither op writes back; busy falls the next cycle.
- Reset mid-operation: reset_n low with 2 ops in flight → no wb_valid after release; the next op has normal latency and RR restarts at req0.
